// File: rtl/life_grid_engine.sv
// Conway Game of Life engine: ROWS x COLS grid with load, LFSR randomise and
// counted / free-running evolution, selectable toroidal or dead-edge borders.

// One cell of the B3/S23 rule: counts its (already edge-masked) neighbours.
module life_grid_cell (
    input  logic [8:0] nb,     // 3x3 neighbourhood, centre bit forced to 0
    input  logic       alive,
    output logic       nxt
);
    logic [3:0] cnt;

    // Population count of the neighbourhood (0..8 fits in 4 bits)
    always_comb begin
        cnt = 4'd0;
        for (int i = 0; i < 9; i++) cnt = cnt + {3'b000, nb[i]};
    end

    assign nxt = (cnt == 4'd3) || (alive && (cnt == 4'd2));
endmodule

module life_grid_engine #(
    parameter int          ROWS = 8,
    parameter int          COLS = 8,
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           cmd,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ROWS*COLS-1:0] load_grid,
    input  logic [15:0]          steps,
    input  logic                 wrap,
    input  logic                 stop_on_stable,
    input  logic                 abort,
    output logic [ROWS*COLS-1:0] grid,
    output logic [15:0]          gen_count,
    output logic                 busy,
    output logic                 done,
    output logic                 stable
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);

    localparam logic [1:0] CMD_LOAD   = 2'b01;
    localparam logic [1:0] CMD_RUN    = 2'b10;
    localparam logic [1:0] CMD_RANDOM = 2'b11;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t           state;
    logic [31:0]      lfsr;
    logic [31:0]      lfsr_next;
    logic [IDX_W-1:0] idx;
    logic [15:0]      remaining;
    logic             counted;
    logic             wrap_q;
    logic             sos_q;
    logic [N-1:0]     next_grid;
    logic             still;
    logic             last_gen;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Galois step: shift right, fold taps back in when a 1 falls out
    always_comb begin
        lfsr_next = lfsr >> 1;
        if (lfsr[0]) lfsr_next = lfsr_next ^ LFSR_TAPS;
    end

    // Neighbourhood wiring. Wrapped coordinates equal in-grid ones whenever the
    // neighbour really is inside the grid, so dead-edge mode only needs a mask.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [8:0] nb;
            for (genvar k = 0; k < 9; k++) begin : g_nb
                localparam int   DR = (k / 3) - 1;
                localparam int   DC = (k % 3) - 1;
                localparam int   RR = (r + DR + ROWS) % ROWS;
                localparam int   CC = (c + DC + COLS) % COLS;
                localparam logic IN = (r + DR >= 0) && (r + DR < ROWS) &&
                                      (c + DC >= 0) && (c + DC < COLS);
                if (k == 4) begin : g_ctr
                    assign nb[k] = 1'b0;
                end else begin : g_side
                    assign nb[k] = grid[RR*COLS+CC] & (wrap_q | IN);
                end
            end
            life_grid_cell u_cell (
                .nb    (nb),
                .alive (grid[r*COLS+c]),
                .nxt   (next_grid[r*COLS+c])
            );
        end
    end

    assign still    = (next_grid == grid);
    assign last_gen = (counted && (remaining == 16'd1)) || (sos_q && still);

    // Command FSM and datapath registers; done is a single-cycle pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grid      <= '0;
            gen_count <= 16'd0;
            stable    <= 1'b0;
            done      <= 1'b0;
            lfsr      <= SEED;
            idx       <= '0;
            remaining <= 16'd0;
            counted   <= 1'b0;
            wrap_q    <= 1'b0;
            sos_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (cmd)
                            CMD_LOAD: begin
                                grid      <= load_grid;
                                gen_count <= 16'd0;
                                stable    <= 1'b0;
                                done      <= 1'b1;
                            end
                            CMD_RUN: begin
                                state     <= RUN;
                                remaining <= steps;
                                counted   <= (steps != 16'd0);
                                wrap_q    <= wrap;
                                sos_q     <= stop_on_stable;
                                stable    <= 1'b0;
                            end
                            CMD_RANDOM: begin
                                state  <= FILL;
                                idx    <= '0;
                                stable <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                FILL: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        grid[idx] <= lfsr[0];
                        lfsr      <= lfsr_next;
                        idx       <= idx + 1'b1;
                        if (idx == IDX_W'(N - 1)) begin
                            gen_count <= 16'd0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        grid      <= next_grid;
                        gen_count <= gen_count + 16'd1;
                        stable    <= still;
                        if (counted) remaining <= remaining - 16'd1;
                        if (last_gen) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_life_grid_engine.sv
// Scoreboarded bench for life_grid_engine: stimulus pushes expected completion
// results, a negedge monitor pops and compares on every done pulse.
module tb_life_grid_engine;
    localparam int          ROWS = 8;
    localparam int          COLS = 8;
    localparam int          N    = ROWS * COLS;
    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic          clk;
    logic          reset;
    logic [1:0]    cmd;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [N-1:0]  load_grid;
    logic [15:0]   steps;
    logic          wrap;
    logic          stop_on_stable;
    logic          abort;
    logic [N-1:0]  grid;
    logic [15:0]   gen_count;
    logic          busy;
    logic          done;
    logic          stable;

    life_grid_engine #(.ROWS(ROWS), .COLS(COLS), .SEED(SEED)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd            (cmd),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .load_grid      (load_grid),
        .steps          (steps),
        .wrap           (wrap),
        .stop_on_stable (stop_on_stable),
        .abort          (abort),
        .grid           (grid),
        .gen_count      (gen_count),
        .busy           (busy),
        .done           (done),
        .stable         (stable)
    );

    typedef struct {
        logic [63:0] g;
        logic [15:0] gc;
        logic        st;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [63:0] m_grid;
    logic [15:0] m_gc;
    logic [31:0] m_lfsr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_true(input string name, input logic cond);
        chk(name, {63'b0, cond}, 64'd1);
    endtask

    // Reference rule: count the 8 neighbours by plain coordinate arithmetic
    function automatic logic [63:0] model_next(input logic [63:0] g, input logic w);
        logic [63:0] n;
        int cnt, rr, cc;
        n = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
                            if (w) begin
                                rr = (rr + ROWS) % ROWS;
                                cc = (cc + COLS) % COLS;
                                cnt += int'(g[rr*COLS+cc]);
                            end else if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                                cnt += int'(g[rr*COLS+cc]);
                            end
                        end
                    end
                end
                n[r*COLS+c] = (cnt == 3) || (g[r*COLS+c] && cnt == 2);
            end
        end
        return n;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    task automatic push(input logic [63:0] g, input logic [15:0] gc, input logic st);
        exp_t e;
        e.g  = g;
        e.gc = gc;
        e.st = st;
        sb.push_back(e);
    endtask

    task automatic model_load(input logic [63:0] g);
        m_grid = g;
        m_gc   = 16'd0;
        push(m_grid, m_gc, 1'b0);
    endtask

    task automatic model_fill();
        for (int i = 0; i < N; i++) begin
            m_grid[i] = m_lfsr[0];
            m_lfsr    = lfsr_step(m_lfsr);
        end
        m_gc = 16'd0;
        push(m_grid, m_gc, 1'b0);
    endtask

    // Evolve until the step count is reached or, if requested, the pattern is still
    task automatic model_run(input int n, input logic w, input logic s);
        logic [63:0] nx;
        logic        st;
        st = 1'b0;
        for (int i = 0; i < n; i++) begin
            nx     = model_next(m_grid, w);
            st     = (nx == m_grid);
            m_grid = nx;
            m_gc   = m_gc + 16'd1;
            if (s && st) break;
        end
        push(m_grid, m_gc, st);
    endtask

    // Present a command at a negedge; returns 1 ns after the accepting edge
    task automatic issue(input logic [1:0] c, input logic [63:0] lg, input logic [15:0] st,
                         input logic w, input logic s);
        int t;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            errors++;
            checks++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1");
        end
        cmd            = c;
        load_grid      = lg;
        steps          = st;
        wrap           = w;
        stop_on_stable = s;
        cmd_valid      = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = 2'b00;
    endtask

    // Cycles counted inclusive of the negedge where done is first seen
    task automatic wait_done(output int lat, output int bcyc);
        logic seen;
        lat  = 0;
        bcyc = 0;
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) bcyc++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within 5000 cycles");
        end else begin
            chk("done_busy_low", {63'b0, busy}, 64'd0);
            chk("done_ready_high", {63'b0, cmd_ready}, 64'd1);
            @(negedge clk);
            chk("done_one_cycle", {63'b0, done}, 64'd0);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done expected none");
            end else begin
                e = sb.pop_front();
                chk("sb_grid", grid, e.g);
                chk("sb_gen_count", {48'b0, gen_count}, {48'b0, e.gc});
                chk("sb_stable", {63'b0, stable}, {63'b0, e.st});
            end
        end
    end

    initial begin
        int          lat, bcyc;
        logic [63:0] g, prev, blinker, glider, block;
        logic [15:0] st;
        logic        w, s;

        blinker = 64'h0000_0000_1C00_0000;
        glider  = 64'h0000_0000_0007_0402;
        block   = 64'h0000_0000_0000_0303;

        reset = 1'b1; cmd = 2'b00; cmd_valid = 1'b0; load_grid = '0; steps = 16'd0;
        wrap = 1'b0; stop_on_stable = 1'b0; abort = 1'b0;
        m_grid = '0; m_gc = 16'd0; m_lfsr = SEED;
        #1;
        chk("rst_grid", grid, 64'd0);
        chk("rst_gen_count", {48'b0, gen_count}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_stable", {63'b0, stable}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_ready", {63'b0, cmd_ready}, 64'd1);
        @(negedge clk);
        reset = 1'b0;

        // NOP is accepted silently; the monitor flags any done it raises
        issue(2'b00, 64'hFFFF, 16'd3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("nop_grid", grid, 64'd0);

        // Blinker oscillation
        model_load(blinker);
        issue(2'b01, blinker, 16'd0, 1'b0, 1'b0);
        chk("load_visible", grid, blinker);
        wait_done(lat, bcyc);
        model_run(1, 1'b0, 1'b0);
        issue(2'b10, '0, 16'd1, 1'b0, 1'b0);
        wait_done(lat, bcyc);
        chk("blinker_lat", 64'(lat), 64'd2);
        chk("blinker_vertical", grid, 64'h0000_0008_0808_0000);
        model_run(1, 1'b0, 1'b0);
        issue(2'b10, '0, 16'd1, 1'b0, 1'b0);
        wait_done(lat, bcyc);
        chk("blinker_restored", grid, blinker);
        chk("blinker_gc2", {48'b0, gen_count}, 64'd2);

        // Glider returns to its start after 32 generations on the torus
        model_load(glider);
        issue(2'b01, glider, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bcyc);
        model_run(32, 1'b1, 1'b0);
        issue(2'b10, '0, 16'd32, 1'b1, 1'b0);
        wait_done(lat, bcyc);
        chk("torus_busy_cycles", 64'(bcyc), 64'd32);
        chk("torus_lat", 64'(lat), 64'd33);
        chk("torus_grid", grid, glider);
        chk("torus_gc", {48'b0, gen_count}, 64'd32);

        // Glider against dead edges, compared every generation
        model_load(glider);
        issue(2'b01, glider, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bcyc);
        model_run(40, 1'b0, 1'b0);
        issue(2'b10, '0, 16'd40, 1'b0, 1'b0);
        g = glider;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            g = model_next(g, 1'b0);
            chk("edge_gen", grid, g);
        end
        wait_done(lat, bcyc);
        chk_true("edge_changed", grid != glider);

        // Still life stops after one generation
        model_load(block);
        issue(2'b01, block, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bcyc);
        model_run(100, 1'b0, 1'b1);
        issue(2'b10, '0, 16'd100, 1'b0, 1'b1);
        wait_done(lat, bcyc);
        chk("still_lat", 64'(lat), 64'd2);
        chk("still_grid", grid, block);
        chk("still_stable", {63'b0, stable}, 64'd1);
        chk("still_gc", {48'b0, gen_count}, 64'd1);

        // RANDOM fills from the LFSR, first output bit goes to cell 0
        model_fill();
        issue(2'b11, '0, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bcyc);
        chk("random_lat", 64'(lat), 64'(N + 1));
        chk("random_grid", grid, m_grid);
        chk_true("random_nonzero", grid != 64'd0);
        prev = grid;
        model_fill();
        issue(2'b11, '0, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bcyc);
        chk_true("random_differs", grid != prev);

        // Randomised load + run pairs
        for (int t = 0; t < 10; t++) begin
            g  = {$urandom, $urandom};
            if (t % 2 == 1) g = g & {$urandom, $urandom};
            st = 16'($urandom_range(1, 24));
            w  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            model_load(g);
            issue(2'b01, g, 16'd0, 1'b0, 1'b0);
            wait_done(lat, bcyc);
            model_run(int'(st), w, s);
            issue(2'b10, '0, st, w, s);
            wait_done(lat, bcyc);
        end

        // Free-run aborted after five generations
        model_load(blinker);
        issue(2'b01, blinker, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bcyc);
        issue(2'b10, '0, 16'd0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        model_run(5, 1'b0, 1'b0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_done(lat, bcyc);
        repeat (3) @(negedge clk);
        chk("abort_no_update", grid, m_grid);
        chk("abort_gc", {48'b0, gen_count}, 64'd5);

        // Abort while idle is ignored
        abort = 1'b1;
        repeat (2) @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_grid", grid, m_grid);

        // Reset in the middle of a run discards it without done
        g = {$urandom, $urandom};
        model_load(g);
        issue(2'b01, g, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bcyc);
        issue(2'b10, '0, 16'd50, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_grid", grid, 64'd0);
        chk("mid_rst_gc", {48'b0, gen_count}, 64'd0);
        chk("mid_rst_busy", {63'b0, busy}, 64'd0);
        chk("mid_rst_done", {63'b0, done}, 64'd0);
        chk("mid_rst_stable", {63'b0, stable}, 64'd0);
        chk("mid_rst_ready", {63'b0, cmd_ready}, 64'd1);
        @(negedge clk);
        reset = 1'b0;
        m_grid = '0; m_gc = 16'd0; m_lfsr = SEED;
        repeat (5) @(negedge clk);
        chk("post_rst_grid", grid, 64'd0);

        // LFSR is back at its seed after reset
        model_fill();
        issue(2'b11, '0, 16'd0, 1'b0, 1'b0);
        wait_done(lat, bcyc);
        chk("reseed_grid", grid, m_grid);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/life_grid_engine.md
# life_grid_engine

Parametrised Conway Game of Life engine with a ROWS×COLS cell grid. It generalises the fixed 8×8 grid/evolve/LFSR datapath into one controller with a command handshake. Supported operations: load a grid, randomise it from an internal LFSR, or run a counted or free-running number of generations. Boundaries are selectable per command: toroidal or dead-edge. Optional early stop when the pattern becomes still. It sits between the top-level mode/IO logic and the display, which reads `grid` directly.

## Interface
- ROWS, 8, grid rows (≥3)
- COLS, 8, grid columns (≥3)
- SEED, 32'hACE1_0001, LFSR reset value (must be nonzero)
- N (localparam) = ROWS*COLS; cell (r,c) is bit r*COLS+c; row 0 is at the LSBs.

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cmd  in  2  00 NOP, 01 LOAD, 10 RUN, 11 RANDOM
- cmd_valid  in  1  command request
- cmd_ready  out  1  high iff state IDLE (combinational from state)
- load_grid  in  N  LOAD payload
- steps  in  16  RUN generation count; 0 = free-run
- wrap  in  1  1 = toroidal, 0 = out-of-grid neighbours dead; sampled at accept
- stop_on_stable  in  1  sampled at accept
- abort  in  1  terminates RUN/FILL
- grid  out  N  current generation (registered)
- gen_count  out  16  generations since last LOAD/RANDOM completion; wraps at 2^16
- busy  out  1  high in FILL or RUN
- done  out  1  one-cycle registered pulse at command completion
- stable  out  1  last computed generation equalled its predecessor

## Operation
- States: IDLE, FILL, RUN.
- Accept = cmd_valid && cmd_ready at a rising edge. cmd NOP is accepted with no effect and no done.
- IDLE + LOAD:
  - grid ← load_grid, gen_count ← 0, stable ← 0, done ← 1.
  - Stay in IDLE.
- IDLE + RANDOM:
  - → FILL; idx ← 0, stable ← 0.
  - Each FILL edge: grid[idx] ← lfsr[0]; LFSR advances; idx++.
  - On the edge writing idx=N-1: gen_count ← 0, done ← 1, → IDLE.
  - Bits not yet written keep their previous values.
- LFSR: 32-bit Galois, shift right; if the shifted-out bit is 1, XOR with 32'h8020_0003.
  - Advances only in FILL.
  - Is not reseeded between fills.
- IDLE + RUN:
  - → RUN; remaining ← steps; latch wrap and stop_on_stable; stable ← 0.
- RUN, per edge:
  - grid ← next(grid).
  - gen_count++.
  - stable ← (next==grid).
  - remaining decrements (when steps≠0).
- next(): B3/S23 rule.
  - Neighbour count 0–8 (4-bit), all N cells computed in parallel, combinational.
  - Dead cell with count 3 → live.
  - Live cell with count 2 or 3 → live.
  - All other cells → dead.
- RUN exits to IDLE with done ← 1 on the edge that:
  - produces generation number `steps` (steps≠0), or
  - produces next==grid while stop_on_stable is latched. This applies even if remaining>1.
- abort (FILL or RUN) has priority over the update on that edge:
  - no grid/gen_count/LFSR change;
  - → IDLE, done ← 1.
  - abort in IDLE is ignored.
- A 1×N or N×1 degenerate grid is not supported (ROWS,COLS ≥3).

## Timing
- Reset values: grid 0, gen_count 0, lfsr SEED, state IDLE, done 0, stable 0, busy 0, cmd_ready 1. Reset mid-FILL/RUN discards the operation immediately; no done.
- LOAD: grid and done are visible in the cycle after the accept edge.
- RUN, steps=k≥1: accept at edge E0; generations at E1..Ek; after Ek, done=1 for one cycle, busy=0, and cmd_ready=1. Throughput is 1 generation/clock.
- RANDOM: N fill edges after accept. done is visible after edge E_N; total N+1 cycles from accept to done.
- busy=1 exactly while in FILL/RUN.
- cmd_valid while busy is not accepted. The requester holds it until cmd_ready.

## Test plan
- Blinker: LOAD 64'h0000_0000_1C00_0000, RUN steps=1 wrap=0 → grid=64'h0000_0008_0808_0000, gen_count=1, done after 1 generation. RUN steps=1 again → original pattern restored, gen_count=2.
- Glider torus: LOAD 64'h0000_0000_0007_0402, RUN steps=32 wrap=1 → grid equals the loaded value, gen_count=32. busy is high exactly 32 cycles.
- Glider dead-edge: same LOAD, wrap=0, steps=40 → grid ≠ loaded pattern and no cell ever wraps to row 0/col 0. Checked against a reference model each cycle.
- Still life: LOAD 64'h0000_0000_0000_0303, RUN steps=100 stop_on_stable=1 → done after 1 generation, stable=1, gen_count=1, grid unchanged.
- RANDOM from reset: done exactly 65 cycles after accept; grid equals the model LFSR bit stream (bit 0 first); grid≠0. A second RANDOM gives a different grid.
- Abort and reset: RUN steps=0 on blinker, abort after 5 generations → gen_count=5, done pulse, no 6th update. Assert reset during a subsequent RUN → all outputs return to reset values with no done.
